pipe_hazard_ctrl: RTL and testbench

- Central stall/bubble sequencer for the 5-stage MIPS pipeline.
- Drives the stall/bubble pair of every pipeline register bank: F (PC), D, E, M, W. Bank X latches the outputs of the stage before it.
- Resolves four hazard classes: load-use, taken-branch flush, multi-cycle mul/div occupancy in E, and data-memory wait states in M.
- Register-bank semantics: stall = hold contents; bubble = load the bubble value. This block never asserts both on the same bank in one cycle.

---
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard-detect inputs and stall/bubble controls of the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       d_branch_taken;
  logic       e_wreg;
  logic       e_m2reg;
  logic [4:0] e_rn;
  logic       e_md_start;
  logic       m_mem_req;
  logic       dmem_ack;

  logic       f_stall;
  logic       d_stall;
  logic       d_bubble;
  logic       e_stall;
  logic       e_bubble;
  logic       m_stall;
  logic       m_bubble;
  logic       w_stall;
  logic       w_bubble;
  logic       md_busy;

  // Pipeline side: reports hazard terms, consumes the bank controls.
  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_branch_taken,
           e_wreg, e_m2reg, e_rn, e_md_start, m_mem_req, dmem_ack,
    input  f_stall, d_stall, d_bubble, e_stall, e_bubble,
           m_stall, m_bubble, w_stall, w_bubble, md_busy
  );

  // Sequencer side.
  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_branch_taken,
           e_wreg, e_m2reg, e_rn, e_md_start, m_mem_req, dmem_ack,
    output f_stall, d_stall, d_bubble, e_stall, e_bubble,
           m_stall, m_bubble, w_stall, w_bubble, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/bubble sequencer for the 5-stage pipeline (load-use,
//            branch flush, mul/div occupancy, dmem wait states).
//            Optional perf counters: define PIPE_HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MD_LAT     = 4,
  parameter int DELAY_SLOT = 1
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_memwait_cnt,
  output logic [31:0]       perf_md_cnt,
  output logic [31:0]       perf_loaduse_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] c_md_init  = 4'(MD_LAT - 1);
  localparam logic       c_flush_en = (DELAY_SLOT == 0);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_md_cnt, w_md_cnt_nxt;

  logic w_memwait, w_mdhold, w_loaduse, w_flush;
  logic w_rs_hit, w_rt_hit;
  logic w_sel_mw, w_sel_md, w_sel_lu, w_sel_fl;

  assign w_memwait = hz.m_mem_req & ~hz.dmem_ack;
  assign w_mdhold  = ((r_state == RUN) & hz.e_md_start) |
                     ((r_state == MD_BUSY) & (r_md_cnt != 4'd0));
  assign w_rs_hit  = hz.d_use_rs & (hz.d_rs == hz.e_rn);
  assign w_rt_hit  = hz.d_use_rt & (hz.d_rt == hz.e_rn);
  assign w_loaduse = hz.e_wreg & hz.e_m2reg & (hz.e_rn != 5'd0) & (w_rs_hit | w_rt_hit);
  assign w_flush   = hz.d_branch_taken & c_flush_en;

  // One-hot winner of the priority chain; a suppressed branch simply re-evaluates next cycle.
  assign w_sel_mw = w_memwait;
  assign w_sel_md = ~w_memwait & w_mdhold;
  assign w_sel_lu = ~w_memwait & ~w_mdhold & w_loaduse;
  assign w_sel_fl = ~w_memwait & ~w_mdhold & ~w_loaduse & w_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // The mul/div unit counts down even while memwait freezes the pipeline.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      RUN: begin
        if (hz.e_md_start && !w_memwait) begin
          w_state_nxt  = MD_BUSY;
          w_md_cnt_nxt = c_md_init;
        end
      end
      MD_BUSY: begin
        if (r_md_cnt != 4'd0) begin
          w_md_cnt_nxt = r_md_cnt - 4'd1;
        end else if (!w_memwait) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    hz.f_stall  = 1'b0;
    hz.d_stall  = 1'b0;
    hz.d_bubble = 1'b0;
    hz.e_stall  = 1'b0;
    hz.e_bubble = 1'b0;
    hz.m_stall  = 1'b0;
    hz.m_bubble = 1'b0;
    hz.w_stall  = 1'b0;
    hz.w_bubble = 1'b0;
    if (resetn) begin
      if (w_sel_mw) begin
        hz.f_stall  = 1'b1;
        hz.d_stall  = 1'b1;
        hz.e_stall  = 1'b1;
        hz.m_stall  = 1'b1;
        hz.w_bubble = 1'b1;
      end else if (w_sel_md) begin
        hz.f_stall  = 1'b1;
        hz.d_stall  = 1'b1;
        hz.e_stall  = 1'b1;
        hz.m_bubble = 1'b1;
      end else if (w_sel_lu) begin
        hz.f_stall  = 1'b1;
        hz.d_stall  = 1'b1;
        hz.e_bubble = 1'b1;
      end else if (w_sel_fl) begin
        hz.d_bubble = 1'b1;
      end
    end
  end

  assign hz.md_busy = (r_state == MD_BUSY);

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_memwait_cnt <= 32'd0;
      perf_md_cnt      <= 32'd0;
      perf_loaduse_cnt <= 32'd0;
      perf_flush_cnt   <= 32'd0;
    end else begin
      if (w_sel_mw) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
      if (w_sel_md) perf_md_cnt      <= perf_md_cnt + 32'd1;
      if (w_sel_lu) perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (w_sel_fl) perf_flush_cnt   <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench; dut_a MD_LAT=4/no delay slot,
//            dut_b MD_LAT=2/delay slot, both fed the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] c_no = 9'b000000000;
  localparam logic [8:0] c_mw = 9'b110101001;
  localparam logic [8:0] c_md = 9'b110100100;
  localparam logic [8:0] c_lu = 9'b110010000;
  localparam logic [8:0] c_fl = 9'b001000000;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] d_rs, d_rt, e_rn;
  logic d_use_rs, d_use_rt, d_branch_taken, e_wreg, e_m2reg, e_md_start, m_mem_req, dmem_ack;
  int n_checks = 0;
  int n_errs   = 0;

  pipe_hazard_ctrl_if ia ();
  pipe_hazard_ctrl_if ib ();

  always #5 clk = ~clk;

  always_comb begin
    ia.d_rs = d_rs; ia.d_rt = d_rt; ia.d_use_rs = d_use_rs; ia.d_use_rt = d_use_rt;
    ia.d_branch_taken = d_branch_taken; ia.e_wreg = e_wreg; ia.e_m2reg = e_m2reg;
    ia.e_rn = e_rn; ia.e_md_start = e_md_start; ia.m_mem_req = m_mem_req; ia.dmem_ack = dmem_ack;
    ib.d_rs = d_rs; ib.d_rt = d_rt; ib.d_use_rs = d_use_rs; ib.d_use_rt = d_use_rt;
    ib.d_branch_taken = d_branch_taken; ib.e_wreg = e_wreg; ib.e_m2reg = e_m2reg;
    ib.e_rn = e_rn; ib.e_md_start = e_md_start; ib.m_mem_req = m_mem_req; ib.dmem_ack = dmem_ack;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] pa_mw, pa_md, pa_lu, pa_fl, pb_mw, pb_md, pb_lu, pb_fl;
`endif

  pipe_hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(0)) dut_a (
    .clk(clk), .resetn(resetn), .hz(ia.slave)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_memwait_cnt(pa_mw), .perf_md_cnt(pa_md),
    .perf_loaduse_cnt(pa_lu), .perf_flush_cnt(pa_fl)
`endif
  );

  pipe_hazard_ctrl #(.MD_LAT(2), .DELAY_SLOT(1)) dut_b (
    .clk(clk), .resetn(resetn), .hz(ib.slave)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_memwait_cnt(pb_mw), .perf_md_cnt(pb_md),
    .perf_loaduse_cnt(pb_lu), .perf_flush_cnt(pb_fl)
`endif
  );

  logic [8:0] ca, cb;
  assign ca = {ia.f_stall, ia.d_stall, ia.d_bubble, ia.e_stall, ia.e_bubble,
               ia.m_stall, ia.m_bubble, ia.w_stall, ia.w_bubble};
  assign cb = {ib.f_stall, ib.d_stall, ib.d_bubble, ib.e_stall, ib.e_bubble,
               ib.m_stall, ib.m_bubble, ib.w_stall, ib.w_bubble};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    d_rs = 5'd0; d_rt = 5'd0; e_rn = 5'd0;
    d_use_rs = 1'b0; d_use_rt = 1'b0; d_branch_taken = 1'b0;
    e_wreg = 1'b0; e_m2reg = 1'b0; e_md_start = 1'b0;
    m_mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Checks the current cycle mid-period, then advances to just after the next edge.
  task automatic step(input string tag, input logic [8:0] ea, input logic ba,
                      input logic [8:0] eb, input logic bb);
    @(negedge clk);
    chk({tag, ".a"}, 32'(ca), 32'(ea));
    chk({tag, ".a_busy"}, 32'(ia.md_busy), 32'(ba));
    chk({tag, ".b"}, 32'(cb), 32'(eb));
    chk({tag, ".b_busy"}, 32'(ib.md_busy), 32'(bb));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_in();
    resetn = 1'b0;
    m_mem_req = 1'b1; e_md_start = 1'b1;
    #2;
    chk("rst.a", 32'(ca), 32'(c_no));
    chk("rst.b", 32'(cb), 32'(c_no));
    chk("rst.a_busy", 32'(ia.md_busy), 32'd0);
    clr_in();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    step("idle", c_no, 1'b0, c_no, 1'b0);

    // Load-use detection and its exclusions
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd5; d_use_rs = 1'b1; d_rs = 5'd5;
    step("lu_rs", c_lu, 1'b0, c_lu, 1'b0);
    d_use_rs = 1'b0; d_rs = 5'd7; d_use_rt = 1'b1; d_rt = 5'd5;
    step("lu_rt", c_lu, 1'b0, c_lu, 1'b0);
    d_rt = 5'd6;
    step("lu_miss", c_no, 1'b0, c_no, 1'b0);
    e_rn = 5'd0; d_rt = 5'd0;
    step("lu_r0", c_no, 1'b0, c_no, 1'b0);
    e_rn = 5'd5; d_rt = 5'd5; e_m2reg = 1'b0;
    step("lu_noload", c_no, 1'b0, c_no, 1'b0);

    // Branch flush, suppressed by a concurrent load-use
    e_m2reg = 1'b1; d_branch_taken = 1'b1;
    step("br_lu", c_lu, 1'b0, c_lu, 1'b0);
    e_wreg = 1'b0;
    step("br", c_fl, 1'b0, c_no, 1'b0);
    clr_in();

    // Plain mul/div: A stalls 4 cycles, B stalls 2
    e_md_start = 1'b1;
    step("md1", c_md, 1'b0, c_md, 1'b0);
    e_md_start = 1'b0;
    step("md2", c_md, 1'b1, c_md, 1'b1);
    step("md3", c_md, 1'b1, c_no, 1'b1);
    step("md4", c_md, 1'b1, c_no, 1'b0);
    step("md5", c_no, 1'b1, c_no, 1'b0);
    step("md6", c_no, 1'b0, c_no, 1'b0);

    // Start blocked by memwait for 5 cycles, then retried
    e_md_start = 1'b1; m_mem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 5; i++) step("mw_retry", c_mw, 1'b0, c_mw, 1'b0);
    dmem_ack = 1'b1;
    step("mw_md1", c_md, 1'b0, c_md, 1'b0);
    step("mw_md2", c_md, 1'b1, c_md, 1'b1);
    step("mw_md3", c_md, 1'b1, c_no, 1'b1);
    e_md_start = 1'b0;
    step("mw_md4", c_md, 1'b1, c_no, 1'b0);
    step("mw_md5", c_no, 1'b1, c_no, 1'b0);
    step("mw_md6", c_no, 1'b0, c_no, 1'b0);
    clr_in();

    // Memwait late in a sequence: A keeps counting, B parks at md_cnt=0
    e_md_start = 1'b1;
    step("hold1", c_md, 1'b0, c_md, 1'b0);
    step("hold2", c_md, 1'b1, c_md, 1'b1);
    m_mem_req = 1'b1; dmem_ack = 1'b0;
    step("hold3", c_mw, 1'b1, c_mw, 1'b1);
    step("hold4", c_mw, 1'b1, c_mw, 1'b1);
    dmem_ack = 1'b1;
    step("hold5", c_no, 1'b1, c_no, 1'b1);
    clr_in();
    step("hold6", c_no, 1'b0, c_no, 1'b0);

    // Reset asserted while A has md_cnt=2
    e_md_start = 1'b1;
    step("rmd1", c_md, 1'b0, c_md, 1'b0);
    step("rmd2", c_md, 1'b1, c_md, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rmd_rst.a", 32'(ca), 32'(c_no));
    chk("rmd_rst.a_busy", 32'(ia.md_busy), 32'd0);
    clr_in();
    @(posedge clk); #1;
    resetn = 1'b1;
    step("rmd_post", c_no, 1'b0, c_no, 1'b0);

    // Counted run: 3 load-use, 4 md (A), 2 memwait, 1 flush (A)
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd9; d_use_rs = 1'b1; d_rs = 5'd9;
    for (int i = 0; i < 3; i++) step("p_lu", c_lu, 1'b0, c_lu, 1'b0);
    clr_in();
    e_md_start = 1'b1;
    step("p_md1", c_md, 1'b0, c_md, 1'b0);
    e_md_start = 1'b0;
    step("p_md2", c_md, 1'b1, c_md, 1'b1);
    step("p_md3", c_md, 1'b1, c_no, 1'b1);
    step("p_md4", c_md, 1'b1, c_no, 1'b0);
    step("p_md5", c_no, 1'b1, c_no, 1'b0);
    m_mem_req = 1'b1;
    for (int i = 0; i < 2; i++) step("p_mw", c_mw, 1'b0, c_mw, 1'b0);
    clr_in();
    d_branch_taken = 1'b1;
    step("p_fl", c_fl, 1'b0, c_no, 1'b0);
    clr_in();
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_lu.a", pa_lu, 32'd3);
    chk("perf_md.a", pa_md, 32'd4);
    chk("perf_mw.a", pa_mw, 32'd2);
    chk("perf_fl.a", pa_fl, 32'd1);
    chk("perf_md.b", pb_md, 32'd2);
    chk("perf_fl.b", pb_fl, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
